result_packer: RTL

RESULT_PACKER -- requirements
Module: result_packer

---
 rtl/result_packer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/result_packer.sv
// result_packer: buffers result hypervectors in a small FIFO and streams each
// one out as BEATS = (DIM+1)/OUT_W beats, lowest bits first. A `last` strobe
// tags the most recent vector (or queues a zero beat) so the stream ends with
// m_last, and `done` pulses one cycle after that beat is accepted.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   run                   accelerator active; low flushes the block
//   store, core_result    one-cycle strobe + vector to enqueue
//   last                  one-cycle end-of-program strobe
//   m_valid/m_ready       output beat handshake
//   m_data, m_last        beat payload, end-of-stream marker
//   done                  one-cycle pulse after the m_last beat is accepted
//   ovf, ovf_cnt          (only with RESULT_PACKER_OVF_EN) sticky drop flag and
//                         saturating count of dropped vectors
module result_packer #(
  parameter int unsigned DIM   = 1023,
  parameter int unsigned OUT_W = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic           store,
  input  logic [DIM:0]   core_result,
  input  logic           last,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic           m_last,
  output logic           done
`ifdef RESULT_PACKER_OVF_EN
  ,
  output logic           ovf,
  output logic [15:0]    ovf_cnt
`endif
);

  localparam int unsigned W     = DIM + 1;
  localparam int unsigned BEATS = W / OUT_W;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_e;

  state_e           state_q, state_d;
  logic             stage_v_q, stage_v_d;
  logic             stage_last_q, stage_last_d;
  logic [W-1:0]     stage_data_q, stage_data_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [DEPTH-1:0] tag_q, tag_d;
  logic             pend_q, pend_d;
  logic             m_valid_q, m_valid_d;
  logic [OUT_W-1:0] m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic             done_q, done_d;

  logic             accept, pop, wr_en;
  logic [CW-1:0]    cnt_left;
  logic [W-1:0]     head_vec;

`ifdef RESULT_PACKER_OVF_EN
  logic             ovf_q, ovf_d;
  logic [15:0]      ovf_cnt_q, ovf_cnt_d;
  logic             drop;
`endif

  // Next-state: FIFO bookkeeping, last-tag handling, registered beat outputs
  always_comb begin
    state_d      = state_q;
    stage_v_d    = run & store;
    stage_last_d = run & last;
    stage_data_d = core_result;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    beat_d       = beat_q;
    tag_d        = tag_q;
    pend_d       = pend_q;
    m_valid_d    = 1'b0;
    m_data_d     = '0;
    m_last_d     = 1'b0;
    done_d       = 1'b0;
    head_vec     = '0;

    accept = m_valid_q & m_ready;
    pop    = accept && (cnt_q != '0) && (beat_q == LAST_BEAT);
    // A full FIFO still accepts the staged vector if the head leaves this cycle
    wr_en  = stage_v_q && ((cnt_q != FULL) || pop);

    if (accept) begin
      if (cnt_q != '0) beat_d = pop ? '0 : beat_q + BW'(1);
      else             pend_d = 1'b0;
    end

    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    cnt_d    = cnt_q + CW'(wr_en) - CW'(pop);
    cnt_left = cnt_q - CW'(pop);

    if (pop) tag_d[rd_ptr_q] = 1'b0;
    if (wr_en) begin
      tag_d[wr_ptr_q] = stage_last_q;
    end else if (stage_last_q) begin
      // Tag the tail entry if it survives this cycle, else queue a zero beat
      if (cnt_left != '0) tag_d[wr_ptr_q - PW'(1)] = 1'b1;
      else                pend_d = 1'b1;
    end

    // Newly written entry is the next head when the FIFO drains to it now
    head_vec = (wr_en && (rd_ptr_d == wr_ptr_q)) ? stage_data_q : mem_q[rd_ptr_d];

    if (cnt_d != '0) begin
      m_valid_d = 1'b1;
      for (int unsigned k = 0; k < BEATS; k++) begin
        if (beat_d == BW'(k)) m_data_d = head_vec[k*OUT_W +: OUT_W];
      end
      m_last_d = (beat_d == LAST_BEAT) && tag_d[rd_ptr_d];
    end else if (pend_d) begin
      m_valid_d = 1'b1;
      m_last_d  = 1'b1;
    end

    unique case (state_q)
      IDLE:    if (m_valid_d)  state_d = SEND;
      SEND:    if (!m_valid_d) state_d = IDLE;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept && m_last_q) state_d = FIN;
    done_d = (state_d == FIN);

`ifdef RESULT_PACKER_OVF_EN
    drop      = stage_v_q && !wr_en;
    ovf_d     = ovf_q | drop;
    ovf_cnt_d = (drop && (ovf_cnt_q != 16'hFFFF)) ? ovf_cnt_q + 16'd1 : ovf_cnt_q;
`endif

    // run low: synchronous flush, store/last ignored
    if (!run) begin
      state_d      = IDLE;
      stage_v_d    = 1'b0;
      stage_last_d = 1'b0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      cnt_d        = '0;
      beat_d       = '0;
      tag_d        = '0;
      pend_d       = 1'b0;
      m_valid_d    = 1'b0;
      m_data_d     = '0;
      m_last_d     = 1'b0;
      done_d       = 1'b0;
`ifdef RESULT_PACKER_OVF_EN
      ovf_d        = 1'b0;
`endif
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      stage_v_q    <= 1'b0;
      stage_last_q <= 1'b0;
      stage_data_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      beat_q       <= '0;
      tag_q        <= '0;
      pend_q       <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      done_q       <= 1'b0;
`ifdef RESULT_PACKER_OVF_EN
      ovf_q        <= 1'b0;
      ovf_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      stage_v_q    <= stage_v_d;
      stage_last_q <= stage_last_d;
      stage_data_q <= stage_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      beat_q       <= beat_d;
      tag_q        <= tag_d;
      pend_q       <= pend_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      done_q       <= done_d;
`ifdef RESULT_PACKER_OVF_EN
      ovf_q        <= ovf_d;
      ovf_cnt_q    <= ovf_cnt_d;
`endif
    end
  end

  // Vector storage; contents are don't-care until pointed to, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= stage_data_q;
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign done    = done_q;
`ifdef RESULT_PACKER_OVF_EN
  assign ovf     = ovf_q;
  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule
